// File: rtl/riscv_fd_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// F/D / D/E hazard sequencer (slave). Clock and reset stay outside.
interface riscv_fd_hazard_ctrl_if #(
  parameter int CNT_W = 32
) ();
  // Pipeline events into the sequencer
  logic             i_riscv_hzc_redirect;
  logic             i_riscv_hzc_lu_hazard;
  logic             i_riscv_hzc_md_start;
  logic             i_riscv_hzc_md_done;
  logic             i_riscv_hzc_imem_ready;
  // Stall/flush controls back to the pipeline registers
  logic             o_riscv_hzc_pc_stall;
  logic             o_riscv_hzc_fd_stall;
  logic             o_riscv_hzc_fd_flush;
  logic             o_riscv_hzc_de_stall;
  logic             o_riscv_hzc_de_flush;
  logic [1:0]       o_riscv_hzc_state;
  logic             o_riscv_hzc_md_timeout;
  logic [CNT_W-1:0] o_riscv_hzc_stall_cycles;

  modport master (
    output i_riscv_hzc_redirect, i_riscv_hzc_lu_hazard, i_riscv_hzc_md_start,
           i_riscv_hzc_md_done, i_riscv_hzc_imem_ready,
    input  o_riscv_hzc_pc_stall, o_riscv_hzc_fd_stall, o_riscv_hzc_fd_flush,
           o_riscv_hzc_de_stall, o_riscv_hzc_de_flush, o_riscv_hzc_state,
           o_riscv_hzc_md_timeout, o_riscv_hzc_stall_cycles
  );

  modport slave (
    input  i_riscv_hzc_redirect, i_riscv_hzc_lu_hazard, i_riscv_hzc_md_start,
           i_riscv_hzc_md_done, i_riscv_hzc_imem_ready,
    output o_riscv_hzc_pc_stall, o_riscv_hzc_fd_stall, o_riscv_hzc_fd_flush,
           o_riscv_hzc_de_stall, o_riscv_hzc_de_flush, o_riscv_hzc_state,
           o_riscv_hzc_md_timeout, o_riscv_hzc_stall_cycles
  );
endinterface

// File: rtl/riscv_fd_hazard_ctrl.sv
// F/D and D/E hazard sequencer: turns redirect, mul/div busy, imem miss and
// load-use events into PC/F/D/D/E stall and flush controls. Stall=1 holds.
module riscv_fd_hazard_ctrl #(
  parameter int FLUSH_CYC  = 2,
  parameter int MD_TIMEOUT = 70,
  parameter int CNT_W      = 32
) (
  input  logic                  i_riscv_hzc_clk,
  input  logic                  i_riscv_hzc_rst_n,
  riscv_fd_hazard_ctrl_if.slave hzc
);

  localparam int                MCNT_W     = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [2:0]        RCNT_LOAD  = 3'(FLUSH_CYC - 1);
  localparam logic [MCNT_W-1:0] MCNT_LAST  = MCNT_W'(MD_TIMEOUT - 1);
  // With a single flush cycle the redirect cycle itself covers it; no REDIR state needed
  localparam bit                REDIR_HOLD = (FLUSH_CYC > 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_REDIR   = 2'd1,
    ST_MD_WAIT = 2'd2,
    ST_IMISS   = 2'd3
  } state_t;

  state_t            r_state, w_state_next;
  logic [2:0]        r_rcnt, w_rcnt_next;
  logic [MCNT_W-1:0] r_mcnt, w_mcnt_next;
  logic              r_md_timeout;
  logic [CNT_W-1:0]  r_stall_cycles;

  logic w_pc_stall, w_fd_stall, w_fd_flush, w_de_stall, w_de_flush;
  logic w_md_tmo_exit;
  logic w_run_rules;

  // Per-cycle event resolution: outputs and next state from state and live inputs
  always_comb begin
    w_pc_stall    = 1'b0;
    w_fd_stall    = 1'b0;
    w_fd_flush    = 1'b0;
    w_de_stall    = 1'b0;
    w_de_flush    = 1'b0;
    w_state_next  = r_state;
    w_rcnt_next   = r_rcnt;
    w_mcnt_next   = r_mcnt;
    w_md_tmo_exit = 1'b0;
    w_run_rules   = 1'b0;

    if (!i_riscv_hzc_rst_n) begin
      // Keep both pipeline registers empty while held in reset
      w_fd_flush = 1'b1;
      w_de_flush = 1'b1;
    end else if (hzc.i_riscv_hzc_redirect) begin
      // Redirect wins in every state; any pending mul/div or miss is abandoned
      w_fd_flush = 1'b1;
      w_de_flush = 1'b1;
      if (REDIR_HOLD) begin
        w_state_next = ST_REDIR;
        w_rcnt_next  = RCNT_LOAD;
      end else begin
        w_state_next = ST_RUN;
      end
    end else begin
      case (r_state)
        ST_REDIR: begin
          // Fetch of the new PC still in flight: keep F/D empty, everything else ignored
          w_fd_flush = 1'b1;
          if (r_rcnt <= 3'd1) begin
            w_rcnt_next  = 3'd0;
            w_state_next = ST_RUN;
          end else begin
            w_rcnt_next = r_rcnt - 3'd1;
          end
        end
        ST_MD_WAIT: begin
          if (hzc.i_riscv_hzc_md_done) begin
            // Result available this cycle; a coincident md_start is dropped
            w_state_next = ST_RUN;
          end else begin
            w_pc_stall = 1'b1;
            w_fd_stall = 1'b1;
            w_de_stall = 1'b1;
            if (r_mcnt == MCNT_LAST) begin
              w_state_next  = ST_RUN;
              w_md_tmo_exit = 1'b1;
            end else begin
              w_mcnt_next = r_mcnt + MCNT_W'(1);
            end
          end
        end
        ST_IMISS: begin
          if (!hzc.i_riscv_hzc_imem_ready) begin
            w_pc_stall = 1'b1;
            w_fd_flush = 1'b1;
          end else begin
            // Miss resolved: this cycle behaves exactly like RUN
            w_run_rules = 1'b1;
          end
        end
        default: w_run_rules = 1'b1;
      endcase

      if (w_run_rules) begin
        w_state_next = ST_RUN;
        if (hzc.i_riscv_hzc_md_start) begin
          // No stall in the issue cycle; waiting starts next cycle
          w_state_next = ST_MD_WAIT;
          w_mcnt_next  = '0;
        end else if (!hzc.i_riscv_hzc_imem_ready) begin
          w_pc_stall   = 1'b1;
          w_fd_flush   = 1'b1;
          w_state_next = ST_IMISS;
        end else if (hzc.i_riscv_hzc_lu_hazard) begin
          // Single bubble: the hazard clears once the load moves on
          w_pc_stall = 1'b1;
          w_fd_stall = 1'b1;
          w_de_flush = 1'b1;
        end
      end
    end
  end

  // State, counters and registered status outputs
  always_ff @(posedge i_riscv_hzc_clk) begin
    if (!i_riscv_hzc_rst_n) begin
      r_state        <= ST_RUN;
      r_rcnt         <= 3'd0;
      r_mcnt         <= '0;
      r_md_timeout   <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_state      <= w_state_next;
      r_rcnt       <= w_rcnt_next;
      r_mcnt       <= w_mcnt_next;
      r_md_timeout <= w_md_tmo_exit;
      if (w_pc_stall && (r_stall_cycles != {CNT_W{1'b1}})) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
    end
  end

  assign hzc.o_riscv_hzc_pc_stall     = w_pc_stall;
  assign hzc.o_riscv_hzc_fd_stall     = w_fd_stall;
  assign hzc.o_riscv_hzc_fd_flush     = w_fd_flush;
  assign hzc.o_riscv_hzc_de_stall     = w_de_stall;
  assign hzc.o_riscv_hzc_de_flush     = w_de_flush;
  assign hzc.o_riscv_hzc_state        = r_state;
  assign hzc.o_riscv_hzc_md_timeout   = r_md_timeout;
  assign hzc.o_riscv_hzc_stall_cycles = r_stall_cycles;

endmodule
